// File: rtl/dds_pkg.sv
// Shared definitions for the DDS frequency sweep controller: FSM state
// encoding, waveform selector codes and default widths.
// Optional feature macro used by the design: DDS_SWEEP_BIDIR_EN.
package dds_pkg;

  localparam int FW_W_DEFAULT    = 32;
  localparam int DWELL_W_DEFAULT = 24;

  localparam logic [1:0] WAVE_SIN = 2'd0;
  localparam logic [1:0] WAVE_SQU = 2'd1;
  localparam logic [1:0] WAVE_TRI = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SWEEP = 2'd1,
    DONE  = 2'd2
  } sweep_state_t;

endpackage

// File: rtl/dds_sweep_ctrl_if.sv
// Configuration bus of the DDS sweep controller. The master side offers a
// complete sweep description with cfg_valid; the controller raises cfg_ready
// whenever it is not in the middle of a sweep.
interface dds_sweep_ctrl_if
  import dds_pkg::*;
#(
  parameter int FW_W    = FW_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
);

  logic               cfg_valid;
  logic               cfg_ready;
  logic [FW_W-1:0]    cfg_start_fw;
  logic [FW_W-1:0]    cfg_stop_fw;
  logic [FW_W-1:0]    cfg_step_fw;
  logic [DWELL_W-1:0] cfg_dwell;
  logic [1:0]         cfg_wave;
  logic               cfg_continuous;

  modport master (
    output cfg_valid, cfg_start_fw, cfg_stop_fw, cfg_step_fw,
           cfg_dwell, cfg_wave, cfg_continuous,
    input  cfg_ready
  );

  modport slave (
    input  cfg_valid, cfg_start_fw, cfg_stop_fw, cfg_step_fw,
           cfg_dwell, cfg_wave, cfg_continuous,
    output cfg_ready
  );

endinterface

// File: rtl/dds_dwell_timer.sv
// Dwell timer: counts enabled cycles and flags the last cycle of every
// window of dwell+1 cycles. load restarts the window from zero and
// suppresses the flag in that cycle.
module dds_dwell_timer
  import dds_pkg::*;
#(
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic               dac_clk,
  input  logic               rst,
  input  logic               load,
  input  logic               enable,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);

  logic [DWELL_W-1:0] count;

  assign expire = enable && !load && (count == dwell);

  // Cycle counter that wraps to zero at the end of each dwell window
  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= '0;
    end else if (enable) begin
      if (count == dwell) begin
        count <= '0;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/dds_sweep_ctrl.sv
// DDS frequency sweep controller. Steps a frequency word from a start value
// to a stop value, holding each value for dwell+1 cycles, optionally looping.
// Define DDS_SWEEP_BIDIR_EN to sweep back down to the start value before the
// sweep ends (or turns around again in continuous mode).
module dds_sweep_ctrl
  import dds_pkg::*;
#(
  parameter int FW_W    = FW_W_DEFAULT,
  parameter int DWELL_W = DWELL_W_DEFAULT
) (
  input  logic            dac_clk,
  input  logic            rst,
  dds_sweep_ctrl_if.slave cfg,
  input  logic            start,
  input  logic            abort,
  output logic [FW_W-1:0] fword,
  output logic [1:0]      wave_change_index,
  output logic            busy,
  output logic            step_tick,
  output logic            sweep_done,
  output logic            cfg_err
);

  sweep_state_t state;

  logic [FW_W-1:0]    sh_start;
  logic [FW_W-1:0]    sh_stop;
  logic [FW_W-1:0]    sh_step;
  logic [DWELL_W-1:0] sh_dwell;
  logic               sh_cont;

  logic               cfg_hs;
  logic [FW_W-1:0]    eff_start;
  logic [FW_W-1:0]    eff_stop;
  logic [FW_W-1:0]    eff_step;
  logic               start_ok;

  logic               timer_load;
  logic               timer_enable;
  logic               dwell_expire;

  logic [FW_W:0]      up_sum;
  logic [FW_W-1:0]    up_next;

`ifdef DDS_SWEEP_BIDIR_EN
  logic               dir_down;
  logic [FW_W:0]      dn_diff;
  logic [FW_W-1:0]    dn_next;
`endif

  assign cfg.cfg_ready = (state != SWEEP);
  assign cfg_hs        = cfg.cfg_valid && cfg.cfg_ready;

  // A start in the same cycle as a handshake must see the config being captured
  assign eff_start = cfg_hs ? cfg.cfg_start_fw : sh_start;
  assign eff_stop  = cfg_hs ? cfg.cfg_stop_fw  : sh_stop;
  assign eff_step  = cfg_hs ? cfg.cfg_step_fw  : sh_step;
  assign start_ok  = (eff_step != '0) && (eff_stop >= eff_start);

  assign timer_load   = start && !abort;
  assign timer_enable = (state == SWEEP);

  // The extra bit catches a carry out, which also lands on the stop value
  assign up_sum  = {1'b0, fword} + {1'b0, sh_step};
  assign up_next = (up_sum >= {1'b0, sh_stop}) ? sh_stop : up_sum[FW_W-1:0];

`ifdef DDS_SWEEP_BIDIR_EN
  // A borrow out of the subtraction means we went below zero, so clamp too
  assign dn_diff = {1'b0, fword} - {1'b0, sh_step};
  assign dn_next = (dn_diff[FW_W] || (dn_diff[FW_W-1:0] <= sh_start)) ? sh_start
                                                                      : dn_diff[FW_W-1:0];
`endif

  dds_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_dwell_timer (
    .dac_clk (dac_clk),
    .rst     (rst),
    .load    (timer_load),
    .enable  (timer_enable),
    .dwell   (sh_dwell),
    .expire  (dwell_expire)
  );

  // Sweep FSM with config shadowing; abort beats start, start beats dwell expiry
  always_ff @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      fword             <= '0;
      wave_change_index <= WAVE_SIN;
      busy              <= 1'b0;
      step_tick         <= 1'b0;
      sweep_done        <= 1'b0;
      cfg_err           <= 1'b0;
      sh_start          <= '0;
      sh_stop           <= '0;
      sh_step           <= '0;
      sh_dwell          <= '0;
      sh_cont           <= 1'b0;
`ifdef DDS_SWEEP_BIDIR_EN
      dir_down          <= 1'b0;
`endif
    end else begin
      step_tick  <= 1'b0;
      sweep_done <= 1'b0;

      if (cfg_hs) begin
        sh_start          <= cfg.cfg_start_fw;
        sh_stop           <= cfg.cfg_stop_fw;
        sh_step           <= cfg.cfg_step_fw;
        sh_dwell          <= cfg.cfg_dwell;
        sh_cont           <= cfg.cfg_continuous;
        wave_change_index <= cfg.cfg_wave;
        cfg_err           <= 1'b0;
      end

      if (abort) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else if (start) begin
        if (!start_ok) begin
          cfg_err <= 1'b1;
          state   <= IDLE;
          busy    <= 1'b0;
        end else begin
          fword <= eff_start;
          state <= SWEEP;
          busy  <= 1'b1;
`ifdef DDS_SWEEP_BIDIR_EN
          dir_down <= 1'b0;
`endif
        end
      end else if ((state == SWEEP) && dwell_expire) begin
`ifdef DDS_SWEEP_BIDIR_EN
        if (!dir_down) begin
          if (fword == sh_stop) begin
            dir_down  <= 1'b1;
            fword     <= dn_next;
            step_tick <= 1'b1;
          end else begin
            fword     <= up_next;
            step_tick <= 1'b1;
          end
        end else if (fword == sh_start) begin
          if (sh_cont) begin
            dir_down  <= 1'b0;
            fword     <= up_next;
            step_tick <= 1'b1;
          end else begin
            state      <= DONE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end
        end else begin
          fword     <= dn_next;
          step_tick <= 1'b1;
        end
`else
        if (fword == sh_stop) begin
          if (sh_cont) begin
            fword     <= sh_start;
            step_tick <= 1'b1;
          end else begin
            state      <= DONE;
            busy       <= 1'b0;
            sweep_done <= 1'b1;
          end
        end else begin
          fword     <= up_next;
          step_tick <= 1'b1;
        end
`endif
      end
    end
  end

endmodule

// File: tb/tb_dds_sweep_ctrl.sv
// Bench for dds_sweep_ctrl. A sweep-list model (the ordered list of
// frequencies one pass visits) predicts every output each cycle; directed
// scenarios add hand-computed expectations. Honours DDS_SWEEP_BIDIR_EN.
module tb_dds_sweep_ctrl;
  import dds_pkg::*;

  localparam int FW_W    = 32;
  localparam int DWELL_W = 24;

  typedef logic [63:0] q64_t[$];

  logic              dac_clk = 1'b0;
  logic              rst     = 1'b1;
  logic              start   = 1'b0;
  logic              abort   = 1'b0;
  logic [FW_W-1:0]   fword;
  logic [1:0]        wave_change_index;
  logic              busy;
  logic              step_tick;
  logic              sweep_done;
  logic              cfg_err;

  dds_sweep_ctrl_if #(.FW_W(FW_W), .DWELL_W(DWELL_W)) cfg_bus ();

  dds_sweep_ctrl #(.FW_W(FW_W), .DWELL_W(DWELL_W)) dut (
    .dac_clk           (dac_clk),
    .rst               (rst),
    .cfg               (cfg_bus),
    .start             (start),
    .abort             (abort),
    .fword             (fword),
    .wave_change_index (wave_change_index),
    .busy              (busy),
    .step_tick         (step_tick),
    .sweep_done        (sweep_done),
    .cfg_err           (cfg_err)
  );

  // Free-running 100 MHz clock
  always #5 dac_clk = ~dac_clk;

  int errors = 0;
  int checks = 0;
  bit cmp_en = 1'b0;

  task automatic checkOutput(input string name, input logic [63:0] actual,
                             input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // The frequencies one pass of the sweep visits, in order
  function automatic q64_t sweep_list(input logic [63:0] lo, input logic [63:0] hi,
                                      input logic [63:0] st);
    q64_t q;
    logic [63:0] v;
    v = lo;
    q.push_back(v);
    while (v != hi) begin
      v = (v + st >= hi) ? hi : v + st;
      q.push_back(v);
    end
`ifdef DDS_SWEEP_BIDIR_EN
    while (v != lo) begin
      v = (v <= lo + st) ? lo : v - st;
      q.push_back(v);
    end
`endif
    return q;
  endfunction

  // Model state
  q64_t        m_list;
  int          m_idx  = 0;
  int          m_hold = 0;
  bit          m_busy = 1'b0;
  bit          m_tick = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err  = 1'b0;
  logic [31:0] m_fword = '0;
  logic [1:0]  m_wave  = '0;
  logic [63:0] s_start = '0;
  logic [63:0] s_stop  = '0;
  logic [63:0] s_step  = '0;
  int          s_dwell = 0;
  bit          s_cont  = 1'b0;

  // Reference model, advanced on each rising clock edge
  always @(posedge dac_clk or posedge rst) begin
    if (rst) begin
      m_list.delete();
      m_idx = 0; m_hold = 0; m_busy = 0; m_tick = 0; m_done = 0; m_err = 0;
      m_fword = '0; m_wave = '0;
      s_start = '0; s_stop = '0; s_step = '0; s_dwell = 0; s_cont = 0;
    end else begin
      m_tick = 0;
      m_done = 0;
      if (cfg_bus.cfg_valid && !m_busy) begin
        s_start = 64'(cfg_bus.cfg_start_fw);
        s_stop  = 64'(cfg_bus.cfg_stop_fw);
        s_step  = 64'(cfg_bus.cfg_step_fw);
        s_dwell = int'(cfg_bus.cfg_dwell);
        s_cont  = cfg_bus.cfg_continuous;
        m_wave  = cfg_bus.cfg_wave;
        m_err   = 0;
      end
      if (abort) begin
        m_busy = 0;
      end else if (start) begin
        if (s_step == 0 || s_stop < s_start) begin
          m_err  = 1;
          m_busy = 0;
        end else begin
          m_list  = sweep_list(s_start, s_stop, s_step);
          m_idx   = 0;
          m_hold  = 0;
          m_fword = m_list[0][31:0];
          m_busy  = 1;
        end
      end else if (m_busy) begin
        m_hold++;
        if (m_hold > s_dwell) begin
          m_hold = 0;
          if (m_idx + 1 < m_list.size()) begin
            m_idx++;
            m_fword = m_list[m_idx][31:0];
            m_tick  = 1;
          end else if (s_cont) begin
`ifdef DDS_SWEEP_BIDIR_EN
            m_idx = (m_list.size() > 1) ? 1 : 0;
`else
            m_idx = 0;
`endif
            m_fword = m_list[m_idx][31:0];
            m_tick  = 1;
          end else begin
            m_busy = 0;
            m_done = 1;
          end
        end
      end
    end
  end

  // Compare all outputs against the model on every falling edge
  always @(negedge dac_clk) begin
    if (cmp_en) begin
      checkOutput("cmp_fword",      64'(fword),             64'(m_fword));
      checkOutput("cmp_busy",       64'(busy),              64'(m_busy));
      checkOutput("cmp_step_tick",  64'(step_tick),         64'(m_tick));
      checkOutput("cmp_sweep_done", 64'(sweep_done),        64'(m_done));
      checkOutput("cmp_cfg_err",    64'(cfg_err),           64'(m_err));
      checkOutput("cmp_wave",       64'(wave_change_index), 64'(m_wave));
      checkOutput("cmp_cfg_ready",  64'(cfg_bus.cfg_ready), 64'(!m_busy));
    end
  end

  // One-cycle config handshake, optionally with start in the same cycle
  task automatic applyStimulus(input logic [31:0] st, input logic [31:0] sp,
                               input logic [31:0] stp, input logic [23:0] dw,
                               input logic [1:0] wv, input bit cont, input bit with_start);
    @(negedge dac_clk);
    cfg_bus.cfg_valid      = 1'b1;
    cfg_bus.cfg_start_fw   = st;
    cfg_bus.cfg_stop_fw    = sp;
    cfg_bus.cfg_step_fw    = stp;
    cfg_bus.cfg_dwell      = dw;
    cfg_bus.cfg_wave       = wv;
    cfg_bus.cfg_continuous = cont;
    start                  = with_start;
    @(negedge dac_clk);
    cfg_bus.cfg_valid = 1'b0;
    start             = 1'b0;
  endtask

  task automatic pulseCmd(input bit is_abort);
    @(negedge dac_clk);
    if (is_abort) abort = 1'b1;
    else          start = 1'b1;
    @(negedge dac_clk);
    abort = 1'b0;
    start = 1'b0;
  endtask

  logic [31:0] trace[$];
  int          done_at;

  // Record fword each cycle until sweep_done, with a cycle budget
  task automatic runSweep(input string name, input int budget);
    trace.delete();
    done_at = -1;
    for (int i = 0; i < budget; i++) begin
      if (sweep_done) begin
        done_at = i;
        break;
      end
      trace.push_back(fword);
      @(negedge dac_clk);
    end
    checkOutput({name, "_done_seen"}, 64'(done_at >= 0), 64'd1);
  endtask

  // Compress the trace into (value, hold) runs and compare with expectations
  task automatic checkRuns(input string name, input logic [31:0] exp_vals[$], input int hold);
    logic [31:0] vals[$];
    int          lens[$];
    foreach (trace[i]) begin
      if (i == 0 || trace[i] != trace[i-1]) begin
        vals.push_back(trace[i]);
        lens.push_back(1);
      end else begin
        lens[lens.size()-1]++;
      end
    end
    checkOutput({name, "_runs"}, 64'(vals.size()), 64'(exp_vals.size()));
    for (int i = 0; i < vals.size() && i < exp_vals.size(); i++) begin
      checkOutput($sformatf("%s_val%0d", name, i), 64'(vals[i]), 64'(exp_vals[i]));
      checkOutput($sformatf("%s_hold%0d", name, i), 64'(lens[i]), 64'(hold));
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not reach the end, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenarios
  initial begin
    q64_t        ml;
    logic [31:0] ev[$];
    logic [31:0] mx;
    logic [31:0] mn;

    cfg_bus.cfg_valid      = 1'b0;
    cfg_bus.cfg_start_fw   = '0;
    cfg_bus.cfg_stop_fw    = '0;
    cfg_bus.cfg_step_fw    = '0;
    cfg_bus.cfg_dwell      = '0;
    cfg_bus.cfg_wave       = '0;
    cfg_bus.cfg_continuous = 1'b0;

    // Pin the sweep-list model with hand-computed lists
    ml = sweep_list(64'd100, 64'd350, 64'd100);
`ifdef DDS_SWEEP_BIDIR_EN
    checkOutput("model_len", 64'(ml.size()), 64'd7);
    checkOutput("model_last", ml[6], 64'd100);
`else
    checkOutput("model_len", 64'(ml.size()), 64'd4);
    checkOutput("model_last", ml[3], 64'd350);
`endif
    checkOutput("model_third", ml[2], 64'd300);

    repeat (2) @(negedge dac_clk);
    cmp_en = 1'b1;
    checkOutput("rst_fword", 64'(fword), 64'd0);
    checkOutput("rst_busy", 64'(busy), 64'd0);
    checkOutput("rst_cfg_ready", 64'(cfg_bus.cfg_ready), 64'd1);
    checkOutput("rst_cfg_err", 64'(cfg_err), 64'd0);
    rst = 1'b0;

    $display("[TB] single sweep 100..400 step 100 dwell 2");
    applyStimulus(32'd100, 32'd400, 32'd100, 24'd2, WAVE_SQU, 1'b0, 1'b0);
    pulseCmd(1'b0);
    runSweep("s1", 60);
`ifdef DDS_SWEEP_BIDIR_EN
    ev = '{32'd100, 32'd200, 32'd300, 32'd400, 32'd300, 32'd200, 32'd100};
    checkRuns("s1", ev, 3);
    checkOutput("s1_done_at", 64'(done_at), 64'd21);
`else
    ev = '{32'd100, 32'd200, 32'd300, 32'd400};
    checkRuns("s1", ev, 3);
    checkOutput("s1_done_at", 64'(done_at), 64'd12);
    checkOutput("s1_fword_end", 64'(fword), 64'd400);
`endif
    checkOutput("s1_busy_end", 64'(busy), 64'd0);

    $display("[TB] saturating sweep 100..350 dwell 0, config and start together");
    applyStimulus(32'd100, 32'd350, 32'd100, 24'd0, WAVE_SIN, 1'b0, 1'b1);
    runSweep("s2", 40);
    mx = '0;
    foreach (trace[i]) if (trace[i] > mx) mx = trace[i];
    checkOutput("s2_max", 64'(mx), 64'd350);
`ifdef DDS_SWEEP_BIDIR_EN
    ev = '{32'd100, 32'd200, 32'd300, 32'd350, 32'd250, 32'd150, 32'd100};
    checkRuns("s2", ev, 1);
`else
    ev = '{32'd100, 32'd200, 32'd300, 32'd350};
    checkRuns("s2", ev, 1);
    checkOutput("s2_done_at", 64'(done_at), 64'd4);
`endif

    $display("[TB] top-of-range sweep, carry out clamps to stop");
    applyStimulus(32'hFFFF_FF00, 32'hFFFF_FFFF, 32'h80, 24'd1, WAVE_TRI, 1'b0, 1'b1);
    runSweep("s3", 40);
    mn = 32'hFFFF_FFFF;
    foreach (trace[i]) if (trace[i] < mn) mn = trace[i];
    checkOutput("s3_min", 64'(mn), 64'hFFFF_FF00);
`ifdef DDS_SWEEP_BIDIR_EN
    ev = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF, 32'hFFFF_FF7F, 32'hFFFF_FF00};
`else
    ev = '{32'hFFFF_FF00, 32'hFFFF_FF80, 32'hFFFF_FFFF};
`endif
    checkRuns("s3", ev, 2);
    mx = fword;

    $display("[TB] invalid configs");
    applyStimulus(32'd10, 32'd100, 32'd0, 24'd0, WAVE_SIN, 1'b0, 1'b1);
    checkOutput("s4_zero_step_err", 64'(cfg_err), 64'd1);
    checkOutput("s4_zero_step_busy", 64'(busy), 64'd0);
    checkOutput("s4_zero_step_fword", 64'(fword), 64'(mx));
    applyStimulus(32'd500, 32'd100, 32'd10, 24'd0, WAVE_SIN, 1'b0, 1'b1);
    checkOutput("s4_reversed_err", 64'(cfg_err), 64'd1);
    pulseCmd(1'b0);
    checkOutput("s4_restart_err", 64'(cfg_err), 64'd1);
    checkOutput("s4_restart_fword", 64'(fword), 64'(mx));
    applyStimulus(32'd10, 32'd30, 32'd10, 24'd0, WAVE_TRI, 1'b0, 1'b0);
    checkOutput("s4_cleared_err", 64'(cfg_err), 64'd0);
    checkOutput("s4_wave", 64'(wave_change_index), 64'(WAVE_TRI));

    $display("[TB] short sweep 10..30 step 10 dwell 0");
    pulseCmd(1'b0);
    runSweep("s6", 30);
`ifdef DDS_SWEEP_BIDIR_EN
    ev = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10};
    checkOutput("s6_done_at", 64'(done_at), 64'd5);
`else
    ev = '{32'd10, 32'd20, 32'd30};
    checkOutput("s6_done_at", 64'(done_at), 64'd3);
`endif
    checkRuns("s6", ev, 1);

    $display("[TB] continuous sweep wrap, restart and abort");
    applyStimulus(32'd10, 32'd30, 32'd10, 24'd0, WAVE_SQU, 1'b1, 1'b1);
`ifdef DDS_SWEEP_BIDIR_EN
    ev = '{32'd10, 32'd20, 32'd30, 32'd20, 32'd10, 32'd20, 32'd30, 32'd20};
`else
    ev = '{32'd10, 32'd20, 32'd30, 32'd10, 32'd20, 32'd30, 32'd10, 32'd20};
`endif
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("s7_cont%0d", i), 64'(fword), 64'(ev[i]));
      @(negedge dac_clk);
    end
    pulseCmd(1'b0);
    checkOutput("s7_restart_fword", 64'(fword), 64'd10);
    checkOutput("s7_restart_busy", 64'(busy), 64'd1);
    pulseCmd(1'b1);
    checkOutput("s7_abort_busy", 64'(busy), 64'd0);

    $display("[TB] abort on the final cycle of the second dwell");
    applyStimulus(32'd1000, 32'd1300, 32'd100, 24'd3, WAVE_SQU, 1'b1, 1'b1);
    repeat (6) @(negedge dac_clk);
    pulseCmd(1'b1);
    checkOutput("s8_abort_fword", 64'(fword), 64'd1100);
    checkOutput("s8_abort_busy", 64'(busy), 64'd0);
    checkOutput("s8_abort_done", 64'(sweep_done), 64'd0);
    checkOutput("s8_abort_ready", 64'(cfg_bus.cfg_ready), 64'd1);

    $display("[TB] asynchronous reset mid-sweep");
    pulseCmd(1'b0);
    repeat (5) @(negedge dac_clk);
    checkOutput("s9_pre_rst_fword", 64'(fword), 64'd1100);
    @(posedge dac_clk);
    #2 rst = 1'b1;
    #1;
    checkOutput("s9_rst_fword", 64'(fword), 64'd0);
    checkOutput("s9_rst_busy", 64'(busy), 64'd0);
    checkOutput("s9_rst_wave", 64'(wave_change_index), 64'd0);
    checkOutput("s9_rst_ready", 64'(cfg_bus.cfg_ready), 64'd1);
    repeat (2) @(negedge dac_clk);
    rst = 1'b0;
    @(negedge dac_clk);
    checkOutput("s9_post_busy", 64'(busy), 64'd0);
    checkOutput("s9_post_fword", 64'(fword), 64'd0);
    checkOutput("s9_post_err", 64'(cfg_err), 64'd0);
    @(negedge dac_clk);

    cmp_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/dds_sweep_ctrl.md
DDS_SWEEP_CTRL -- requirements
Module: dds_sweep_ctrl

Interface
REQ-001 The block SHALL have parameter FW_W, default 32, giving the frequency-control-word width.
REQ-002 The block SHALL have parameter DWELL_W, default 24, giving the dwell-counter width.
REQ-003 Port dac_clk SHALL be an input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 Port rst SHALL be an input, 1 bit: asynchronous, active-high reset.
REQ-005 The config ports SHALL be inputs: cfg_valid (1), cfg_start_fw, cfg_stop_fw and cfg_step_fw (each FW_W), cfg_dwell (DWELL_W), cfg_wave (2), cfg_continuous (1).
REQ-006 Port cfg_ready SHALL be an output, 1 bit: the block accepts config when cfg_valid and cfg_ready are both high.
REQ-007 Ports start and abort SHALL be inputs, 1 bit each: single-cycle command pulses.
REQ-008 Port fword SHALL be an output, FW_W bits: the registered frequency word driven to the DDS phase accumulator.
REQ-009 Port wave_change_index SHALL be an output, 2 bits: 0 = sine, 1 = square, 2 = triangle.
REQ-010 Ports busy, step_tick, sweep_done and cfg_err SHALL be outputs, 1 bit each: sweeping, a fword-change pulse, an end-of-sweep pulse, and a sticky config error.

Function
REQ-011 The FSM SHALL have the states IDLE, SWEEP and DONE.
REQ-012 cfg_ready SHALL equal (state != SWEEP).
- On a config handshake, the shadow registers capture all cfg_* fields and cfg_err clears.
- wave_change_index updates from cfg_wave on the next cycle.
REQ-013 A start in IDLE or DONE SHALL be validated against the shadow config.
- If step == 0 or stop < start (unsigned), the block sets cfg_err, stays in or returns to IDLE, and leaves fword unchanged.
- Otherwise, on the next cycle, fword = start, the state is SWEEP, busy = 1, the dwell count = 0 and the direction = up.
REQ-014 In SWEEP, each frequency SHALL be held for exactly dwell+1 cycles.
- dwell = 0 gives a change every cycle.
REQ-015 On dwell expiry while going up, the block SHALL compute next = fword + step in FW_W+1 bits.
- If next >= stop, or the addition carries out, fword = stop; otherwise fword = next.
- step_tick pulses in the same cycle fword changes.
REQ-016 On dwell expiry while fword == stop (non-bidirectional build), the block SHALL end the sweep.
- With continuous = 1: fword = start, step_tick pulses, and the sweep continues.
- With continuous = 0: state = DONE, busy = 0, sweep_done pulses for 1 cycle, and fword holds stop.
REQ-017 abort SHALL take priority over start and over dwell expiry.
- In SWEEP, the next cycle has state = IDLE, busy = 0, fword holding its current value, and no sweep_done.
REQ-018 A start during SWEEP SHALL restart the sweep from start exactly as in REQ-013.
REQ-019 A config handshake and a start in the same cycle SHALL validate and use the newly captured config.
REQ-020 start and cfg_valid in DONE SHALL behave as in IDLE; DONE exits to IDLE on abort.

Reset
REQ-021 While rst = 1, the block SHALL hold state = IDLE, fword = 0, wave_change_index = 0, busy = step_tick = sweep_done = cfg_err = 0, cfg_ready = 1, and all shadow registers and the dwell count = 0.
REQ-022 A reset asserted mid-sweep SHALL take effect asynchronously; the block leaves reset in IDLE.

Configuration
REQ-023 Macro DDS_SWEEP_BIDIR_EN SHALL control bidirectional sweep.
- When defined: on dwell expiry at fword == stop going up, the direction flips to down and fword steps by -step, saturating at start.
- Still defined: on dwell expiry at fword == start going down, the block ends the sweep per REQ-016.
- With continuous = 1 in that case, the direction flips to up and the sweep continues without re-emitting start.
- When undefined: direction logic is absent and REQ-016 applies as written.

Structure
REQ-024 The shared package dds_pkg SHALL hold the FSM state enum, the WAVE_SIN/WAVE_SQU/WAVE_TRI constants and the default FW_W.
REQ-025 The dwell counter SHALL be a sub-module dds_dwell_timer.
- Inputs: load, enable, dwell.
- Output: expire, a pulse every dwell+1 enabled cycles, restarted by load.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- start=100, stop=400, step=100, dwell=2, single -> fword 100,200,300,400, each held 3 cycles; sweep_done 3 cycles after 400 appears; busy falls.
- start=100, stop=350, step=100, dwell=0 -> fword 100,200,300,350, then done; no value above 350.
- start=0xFFFFFF00, stop=0xFFFFFFFF, step=0x80 -> 0xFFFFFF00, 0xFFFFFF80, 0xFFFFFFFF; no wrap to a low value.
- step=0 or stop<start, then start -> cfg_err=1, busy=0, fword unchanged; a valid config clears cfg_err.
- abort at the second dwell of a continuous sweep, and rst mid-sweep -> IDLE next cycle with fword held; after rst, all outputs at reset values.
- DDS_SWEEP_BIDIR_EN, start=10, stop=30, step=10, dwell=0 -> 10,20,30,20,10, then sweep_done.
